// File: rtl/ctrl_pipe_dec.sv
// Main control decoder with registered ID/EX, EX/MEM and MEM/WB control stages
// and a multi-cycle sequencer that holds mult/div in EX for MDU_CYCLES cycles.
module ctrl_pipe_dec #(
    parameter int ALUOP_W    = 3,
    parameter int MDU_CYCLES = 4,
    parameter int MDU_CNT_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               stall,
    input  logic               flush,
    output logic               id_jmp,
    output logic               id_illegal,
    output logic               ex_alusrc,
    output logic [1:0]         ex_regds,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_brnch,
    output logic               ex_brnchne,
    output logic               ex_mdu,
    output logic               mem_memwr,
    output logic               wb_regwr,
    output logic [1:0]         wb_memreg,
    output logic               mdu_busy,
    output logic               mdu_stall
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;

    localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_CYCLES - 1);
    localparam logic [MDU_CNT_W-1:0] CNT_ONE  = MDU_CNT_W'(1);
    localparam logic [MDU_CNT_W-1:0] CNT_TWO  = MDU_CNT_W'(2);

    typedef struct packed {
        logic               regwr;
        logic [1:0]         regds;
        logic [1:0]         memreg;
        logic               memwr;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               brnch;
        logic               brnchne;
        logic               mdu;
    } ctrl_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    ctrl_t                dec_next;
    ctrl_t                idex_reg;
    logic                 exmem_memwr_reg;
    logic                 exmem_regwr_reg;
    logic [1:0]           exmem_memreg_reg;
    logic                 memwb_regwr_reg;
    logic [1:0]           memwb_memreg_reg;
    mdu_state_t           mdu_state_reg;
    logic [MDU_CNT_W-1:0] mdu_cnt_reg;
    logic                 stall_all;

    // An illegal opcode leaves the word all-zero so it travels as a bubble.
    always_comb begin
        dec_next   = '0;
        id_jmp     = 1'b0;
        id_illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec_next.regwr = 1'b1;
                dec_next.regds = 2'd1;
                dec_next.aluop = ALUOP_W'(7);
                dec_next.mdu   = (funct == FN_MULT) || (funct == FN_DIV);
            end
            OP_J:   id_jmp = 1'b1;
            OP_JAL: begin
                dec_next.regwr  = 1'b1;
                dec_next.regds  = 2'd2;
                dec_next.memreg = 2'd2;
                id_jmp          = 1'b1;
            end
            OP_BEQ: begin
                dec_next.brnch = 1'b1;
                dec_next.aluop = ALUOP_W'(1);
            end
            OP_BNE: begin
                dec_next.brnchne = 1'b1;
                dec_next.aluop   = ALUOP_W'(1);
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_next.regwr  = 1'b1;
                dec_next.alusrc = 1'b1;
                case (op)
                    OP_SLTI: dec_next.aluop = ALUOP_W'(3);
                    OP_ANDI: dec_next.aluop = ALUOP_W'(4);
                    OP_ORI:  dec_next.aluop = ALUOP_W'(5);
                    OP_XORI: dec_next.aluop = ALUOP_W'(6);
                    OP_LUI:  dec_next.aluop = ALUOP_W'(2);
                    default: dec_next.aluop = ALUOP_W'(0);
                endcase
            end
            OP_LW: begin
                dec_next.regwr  = 1'b1;
                dec_next.alusrc = 1'b1;
                dec_next.memreg = 2'd1;
            end
            OP_SW: begin
                dec_next.memwr  = 1'b1;
                dec_next.alusrc = 1'b1;
            end
            default: id_illegal = 1'b1;
        endcase
    end

    // The sequencer only samples ex_mdu in IDLE, so the DONE cycle lets the
    // finished op leave ID/EX without restarting on it.
    assign mdu_stall = (mdu_state_reg == S_BUSY) ||
                       ((mdu_state_reg == S_IDLE) && idex_reg.mdu);
    assign mdu_busy  = (mdu_state_reg != S_IDLE);
    assign stall_all = stall || mdu_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdu_state_reg <= S_IDLE;
            mdu_cnt_reg   <= '0;
        end else begin
            case (mdu_state_reg)
                S_IDLE: begin
                    if (idex_reg.mdu) begin
                        mdu_cnt_reg   <= CNT_LOAD;
                        mdu_state_reg <= (CNT_LOAD > CNT_ONE) ? S_BUSY : S_DONE;
                    end
                end
                S_BUSY: begin
                    if (mdu_cnt_reg > CNT_ONE) begin
                        mdu_cnt_reg <= mdu_cnt_reg - CNT_ONE;
                    end
                    if (mdu_cnt_reg <= CNT_TWO) begin
                        mdu_state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    mdu_state_reg <= S_IDLE;
                    mdu_cnt_reg   <= '0;
                end
                default: begin
                    mdu_state_reg <= S_IDLE;
                    mdu_cnt_reg   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_reg         <= '0;
            exmem_memwr_reg  <= 1'b0;
            exmem_regwr_reg  <= 1'b0;
            exmem_memreg_reg <= 2'd0;
            memwb_regwr_reg  <= 1'b0;
            memwb_memreg_reg <= 2'd0;
        end else begin
            if (flush) begin
                idex_reg <= '0;
            end else if (!stall_all) begin
                idex_reg <= dec_next;
            end
            if (stall_all) begin
                exmem_memwr_reg  <= 1'b0;
                exmem_regwr_reg  <= 1'b0;
                exmem_memreg_reg <= 2'd0;
            end else begin
                exmem_memwr_reg  <= idex_reg.memwr;
                exmem_regwr_reg  <= idex_reg.regwr;
                exmem_memreg_reg <= idex_reg.memreg;
            end
            memwb_regwr_reg  <= exmem_regwr_reg;
            memwb_memreg_reg <= exmem_memreg_reg;
        end
    end

    assign ex_alusrc  = idex_reg.alusrc;
    assign ex_regds   = idex_reg.regds;
    assign ex_aluop   = idex_reg.aluop;
    assign ex_brnch   = idex_reg.brnch;
    assign ex_brnchne = idex_reg.brnchne;
    assign ex_mdu     = idex_reg.mdu;
    assign mem_memwr  = exmem_memwr_reg;
    assign wb_regwr   = memwb_regwr_reg;
    assign wb_memreg  = memwb_memreg_reg;

endmodule
